// File: rtl/femto_mem_defs.sv
// ============================================================================
// femto_mem_defs : shared encodings for the unified-memory port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package femto_mem_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_IF = 2'd1;
  localparam logic [1:0] ST_RD_D  = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Loads always read the full word; only stores use the requester's lanes.
  function automatic logic [3:0] data_be(input logic we, input logic [3:0] be);
    return we ? be : BE_FULL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lat_timer.sv
// ============================================================================
// mem_lat_timer : loadable down-counter with a done flag (count == 0)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lat_timer #(
  parameter int MEM_LAT = 1,
  parameter int CW      = $clog2(MEM_LAT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-ported memory between fetch and data
// Optional perf counters: define MEM_ARB_PERF_CNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter import femto_mem_defs::*; #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]   conflict_cnt,
  output logic [15:0]   wait_cnt
`endif
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  logic [1:0]    state_q, state_d;
  logic          pref_q, pref_d;
  logic [DW-1:0] if_hold_q, if_hold_d;
  logic [DW-1:0] d_hold_q, d_hold_d;
  logic          w_idle, w_rd_gnt, w_timer_done;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Grants are combinational on state, so they must also be masked while reset is held.
  assign w_idle = rst & (state_q == ST_IDLE);
  assign if_gnt = w_idle & if_req & (~d_req | (pref_q == REQ_D));
  assign d_gnt  = w_idle & d_req  & (~if_req | (pref_q == REQ_IF));

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_be    = if_gnt ? BE_FULL : (d_gnt ? data_be(d_we, d_be) : 4'h0);
  assign mem_addr  = d_gnt ? d_addr[AW-1:2] : (if_gnt ? if_addr[AW-1:2] : '0);
  assign mem_wdata = mem_we ? d_wdata : '0;

  assign w_rd_gnt  = if_gnt | (d_gnt & ~d_we);
  assign if_rvalid = (state_q == ST_RD_IF) & w_timer_done;
  assign d_rvalid  = (state_q == ST_RD_D)  & w_timer_done;
  assign if_rdata  = if_rvalid ? mem_rdata : if_hold_q;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_hold_q;

  assign busy = rst & ((state_q != ST_IDLE) | (if_req & ~if_gnt) | (d_req & ~d_gnt));

  mem_lat_timer #(.MEM_LAT(MEM_LAT), .CW(CW)) u_lat_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_rd_gnt),
    .load_val_i (CW'(MEM_LAT - 1)),
    .dec_i      (state_q != ST_IDLE),
    .done_o     (w_timer_done)
  );

  always_comb begin
    state_d   = state_q;
    pref_d    = pref_q;
    if_hold_d = if_rvalid ? mem_rdata : if_hold_q;
    d_hold_d  = d_rvalid  ? mem_rdata : d_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (if_gnt) begin
          state_d = ST_RD_IF;
        end else if (d_gnt && !d_we) begin
          state_d = ST_RD_D;
        end
        if (if_gnt && d_req) begin
          pref_d = REQ_IF;
        end else if (d_gnt && if_req) begin
          pref_d = REQ_D;
        end
      end
      ST_RD_IF, ST_RD_D: begin
        if (w_timer_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pref holds the last conflict winner; starting at data lets fetch win the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pref_q    <= REQ_D;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      pref_q    <= pref_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] wait_q, wait_d;

  always_comb begin
    conflict_d = conflict_q;
    wait_d     = wait_q;
    if (w_idle && if_req && d_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
    if (((if_req && !if_gnt) || (d_req && !d_gnt)) && (wait_q != 16'hFFFF)) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
      wait_q     <= '0;
    end else begin
      conflict_q <= conflict_d;
      wait_q     <= wait_d;
    end
  end

  assign conflict_cnt = conflict_q;
  assign wait_cnt     = wait_q;
`endif

endmodule

`default_nettype wire
